// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI character transfer controller.
package spi_pkg;

  localparam int unsigned LEN_W_DEF  = 7;
  localparam int unsigned SS_DLY_DEF = 2;
  localparam int unsigned SS_DLY_MIN = 1;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 2'd1;
  localparam logic [STATE_W-1:0] ST_XFER  = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    XFER  = ST_XFER,
    HOLD  = ST_HOLD
  } xfer_state_t;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Control/strobe bundle between register block, clock generator, shift register and the controller.
// SPI_XFER_IRQ_EN adds the sticky completion interrupt signals.
interface spi_xfer_ctrl_if #(
  parameter int unsigned LEN_W = 7
);
  logic             go;
  logic [LEN_W-1:0] char_len;
  logic             cpol;
  logic             cpha;
  logic             gen_pos_edge;
  logic             gen_neg_edge;
  logic             gen_en;
  logic             ss_n;
  logic             tip;
  logic             load;
  logic             drive;
  logic             sample;
  logic             done;
  logic [LEN_W-1:0] bit_cnt;
`ifdef SPI_XFER_IRQ_EN
  logic             irq_en;
  logic             irq_clr;
  logic             irq;

  modport master (
    output go, char_len, cpol, cpha, gen_pos_edge, gen_neg_edge, irq_en, irq_clr,
    input  gen_en, ss_n, tip, load, drive, sample, done, bit_cnt, irq
  );
  modport slave (
    input  go, char_len, cpol, cpha, gen_pos_edge, gen_neg_edge, irq_en, irq_clr,
    output gen_en, ss_n, tip, load, drive, sample, done, bit_cnt, irq
  );
`else
  modport master (
    output go, char_len, cpol, cpha, gen_pos_edge, gen_neg_edge,
    input  gen_en, ss_n, tip, load, drive, sample, done, bit_cnt
  );
  modport slave (
    input  go, char_len, cpol, cpha, gen_pos_edge, gen_neg_edge,
    output gen_en, ss_n, tip, load, drive, sample, done, bit_cnt
  );
`endif
endinterface

// File: rtl/spi_ss_timer.sv
// Loadable down-counter timing the slave-select setup and hold windows; expired is registered.
module spi_ss_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    expired_d = (cnt_d == '0);
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI character: slave select, generator enable, load/drive/sample strobes, done.
// Optional sticky interrupt when SPI_XFER_IRQ_EN is defined.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned SS_DLY = SS_DLY_DEF
) (
  input  logic           wb_clk_in,
  input  logic           wb_rst,
  spi_xfer_ctrl_if.slave bus
);

  localparam int unsigned CNT_W      = LEN_W + 1;
  localparam int unsigned SS_DLY_EFF = (SS_DLY < SS_DLY_MIN) ? SS_DLY_MIN : SS_DLY;
  localparam int unsigned DLY_W      = (SS_DLY_EFF > 1) ? $clog2(SS_DLY_EFF) : 1;

  xfer_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gen_en_q, gen_en_d;
  logic             ss_n_q, ss_n_d;
  logic             tip_q, tip_d;
  logic             load_q, load_d;
  logic             drive_q, drive_d;
  logic             sample_q, sample_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic             tmr_exp;
  logic [DLY_W-1:0] tmr_val;
  logic [CNT_W-1:0] n_bits;
  logic [CNT_W-1:0] cnt_inc;
  logic             lead;
  logic             trail;

  spi_ss_timer #(.CNT_W(DLY_W)) u_ss_timer (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired   (tmr_exp)
  );

  // char_len of zero means a full 2**LEN_W bit character
  assign n_bits  = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign lead    = cpol_q ? bus.gen_neg_edge : bus.gen_pos_edge;
  assign trail   = cpol_q ? bus.gen_pos_edge : bus.gen_neg_edge;
  assign tmr_val = DLY_W'(SS_DLY_EFF - 1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gen_en_d = gen_en_q;
    ss_n_d   = ss_n_q;
    tip_d    = tip_q;
    load_d   = 1'b0;
    drive_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d  = SETUP;
          len_d    = bus.char_len;
          cpol_d   = bus.cpol;
          cpha_d   = bus.cpha;
          cnt_d    = '0;
          last_d   = 1'b0;
          ss_n_d   = 1'b0;
          tip_d    = 1'b1;
          load_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_exp) begin
          state_d  = XFER;
          gen_en_d = 1'b1;
        end
      end
      XFER: begin
        // Coincident strobes: sampling takes priority and the drive is dropped
        if (!cpha_q) begin
          if (lead) begin
            sample_d = 1'b1;
            cnt_d    = cnt_inc;
            last_d   = (cnt_inc == n_bits);
          end else if (trail) begin
            if (last_q) begin
              state_d  = HOLD;
              gen_en_d = 1'b0;
              tmr_load = 1'b1;
            end else begin
              drive_d = 1'b1;
            end
          end
        end else begin
          if (trail) begin
            sample_d = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == n_bits) begin
              state_d  = HOLD;
              gen_en_d = 1'b0;
              tmr_load = 1'b1;
            end
          end else if (lead) begin
            drive_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Release slave select first; done follows one cycle later on the way to IDLE
        if (tmr_exp) begin
          if (!ss_n_q) begin
            ss_n_d = 1'b1;
            tip_d  = 1'b0;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      gen_en_q <= 1'b0;
      ss_n_q   <= 1'b1;
      tip_q    <= 1'b0;
      load_q   <= 1'b0;
      drive_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gen_en_q <= gen_en_d;
      ss_n_q   <= ss_n_d;
      tip_q    <= tip_d;
      load_q   <= load_d;
      drive_q  <= drive_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign bus.gen_en  = gen_en_q;
  assign bus.ss_n    = ss_n_q;
  assign bus.tip     = tip_q;
  assign bus.load    = load_q;
  assign bus.drive   = drive_q;
  assign bus.sample  = sample_q;
  assign bus.done    = done_q;
  // Low LEN_W bits: a full 2**LEN_W character finishes at 0, matching its char_len encoding
  assign bus.bit_cnt = cnt_q[LEN_W-1:0];

`ifdef SPI_XFER_IRQ_EN
  logic irq_q, irq_d;

  // Sticky completion flag; a coincident set beats the clear
  always_comb begin
    irq_d = irq_q;
    if (bus.irq_clr) irq_d = 1'b0;
    if (done_q && bus.irq_en) irq_d = 1'b1;
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule
